dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the 16-bit CPU's load/store path; the responder end of the CPU's memory request interface.
- Accepts one word request at a time over a valid/ready style handshake and performs the read or write against an internal word-addressed array.
- Answers each request with a single-cycle acknowledge after a programmable number of wait states.
- Sits beside the regfile/ALU datapath; the CPU's memwrite control drives `we`.

Parameters:
- ADDR_W, 8, internal array address width; DEPTH = 2**ADDR_W words of 16 bits.
- WAIT_CYCLES, 2, wait states inserted between accept and acknowledge; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  CPU request valid.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  16  word address from the CPU (ALU result).
- wdata  input  16  write data (regfile read2); sampled with req.
- ready  output  1  responder can accept a request this cycle.
- ack  output  1  one-cycle response strobe.
- rdata  output  16  read data; valid when ack=1 on a read.
- err  output  1  out-of-range flag; valid when ack=1.
- busy  output  1  a request is in flight (accepted, not yet acked).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. It forces IDLE and sets ack=0, err=0, rdata=0, busy=0, wait counter=0, so ready=1 immediately.
- Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
  - ready = (state==IDLE); busy = (state!=IDLE). Both are decoded from registered state.
- Accept: on a rising edge with req=1 and ready=1, the block captures we, addr and wdata into internal registers.
  - Next state is WAIT with counter loaded to WAIT_CYCLES-1, or RESP if WAIT_CYCLES==0.
  - req=0 in IDLE keeps the block in IDLE.
- WAIT: counter decrements each cycle. When the counter is 0, next state is RESP.
  - req and inputs are ignored while in WAIT (ready=0).
- RESP: lasts exactly one cycle, with ack=1 and err and rdata driven from registers updated at the RESP entry edge. Next state is always IDLE.
- Latency: ack is high during cycle N+WAIT_CYCLES+1, where N is the accept cycle. With WAIT_CYCLES=0, ack is high the cycle after accept.
- Range check: the request is out of range when captured addr[15:ADDR_W] != 0.
  - Out-of-range read: err=1, rdata=0.
  - Out-of-range write: err=1, array unchanged.
- Write: the array is updated at the RESP entry edge, only if in range. rdata is unchanged on a write ack.
- Read: rdata = array[addr[ADDR_W-1:0]], registered at the RESP entry edge. rdata holds its value until the next read ack, so it remains stable after ack falls.
- Read-after-write: a read accepted after a write's ack returns the newly written data.
- Back-to-back requests: no accept in the ack cycle. ready rises the cycle after ack, so the minimum request spacing is WAIT_CYCLES+2 cycles.
- Holding req high continuously issues a new request every WAIT_CYCLES+2 cycles. Captured fields come from the accept cycle only.
- err is cleared to 0 outside RESP; ack is never high for two consecutive cycles.
- Reset mid-operation (WAIT or RESP): the transaction is aborted, no ack is produced, and a pending write is not performed.
  - If reset is asserted in the RESP cycle itself, ack drops asynchronously.
- Counter width is 4 bits. WAIT_CYCLES > 15 is illegal; the design is not required to handle it.

Test Plan:
- Write then read, WAIT_CYCLES=2: write addr=0x0005 wdata=0xBEEF (accept cycle 0) -> ack in cycle 3, err=0. Then read addr=0x0005 -> ack 3 cycles after accept, rdata=0xBEEF, err=0.
- Out of range, ADDR_W=8: write addr=0x0105 wdata=0x1234 -> ack with err=1. Then read addr=0x0005 -> rdata=0xBEEF (unchanged). Read addr=0x0100 -> err=1, rdata=0x0000.
- Held req with ready=0: req held high through WAIT, with addr changed to 0x0009 mid-WAIT -> response reflects the captured addr 0x0005. ready=0 and busy=1 for cycles 1..3. Next accept occurs in cycle 4.
- WAIT_CYCLES=0: read addr=0x0005 accepted in cycle 0 -> ack=1 in cycle 1 only. ready=1 again in cycle 2.
- Reset mid-WAIT: write addr=0x0007 wdata=0xAAAA, assert reset in cycle 1 -> ack/busy/err/rdata immediately 0, ready=1, no ack ever. A later read of 0x0007 returns the prior contents, not 0xAAAA.
- rdata hold: read of 0x0005 returns 0xBEEF, then write to 0x0006 -> rdata stays 0xBEEF through and after the write ack.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bus between the CPU load/store path and the data-memory responder.
interface dmem_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        ack;
  logic [15:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, ack, rdata, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering one request at a time with a single-cycle ack
// after WAIT_CYCLES wait states; out-of-range addresses are flagged with err.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic        we_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        ack_r;
  logic        err_r;
  logic [15:0] rdata_r;
  logic [15:0] mem [DEPTH];

  logic              to_resp;
  logic              cur_we;
  logic              cur_oor;
  logic              mem_wr;
  logic [15:0]       cur_addr;
  logic [15:0]       cur_wdata;
  logic [ADDR_W-1:0] cur_idx;

  // With zero wait states RESP is entered straight from the accept edge, so the
  // request fields come from the bus rather than the capture registers.
  always_comb begin
    to_resp   = ((state == StIdle) && bus.req && (WAIT_CYCLES == 0)) ||
                ((state == StWait) && (cnt == 4'd0));
    cur_we    = (state == StIdle) ? bus.we    : we_r;
    cur_addr  = (state == StIdle) ? bus.addr  : addr_r;
    cur_wdata = (state == StIdle) ? bus.wdata : wdata_r;
    cur_oor   = (cur_addr >> ADDR_W) != 16'd0;
    cur_idx   = cur_addr[ADDR_W-1:0];
    mem_wr    = to_resp && cur_we && !cur_oor && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 16'd0;
      wdata_r <= 16'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 16'd0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.req) begin
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            cnt     <= WAIT_LOAD;
            state   <= (WAIT_CYCLES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt == 4'd0) state <= StResp;
          else             cnt   <= cnt - 4'd1;
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
      if (to_resp) begin
        ack_r <= 1'b1;
        err_r <= cur_oor;
        if (!cur_we) rdata_r <= cur_oor ? 16'd0 : mem[cur_idx];
      end
    end
  end

  // Array has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[cur_idx] <= cur_wdata;
  end

  assign bus.ready = (state == StIdle);
  assign bus.busy  = (state != StIdle);
  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against an
// array-based reference model; instances with 2 and 0 wait states.
module tb_dmem_responder;
  localparam int unsigned WA    = 2;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(WA)) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model for instance A
  logic [15:0] mm [DEPTH];
  bit          mv [DEPTH];
  logic [15:0] last_rd;
  bit          last_known;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete transaction on instance A, checked against the model.
  task automatic a_txn(input logic w, input logic [15:0] ad, input logic [15:0] wd);
    int          lat;
    bit          in_r;
    logic [15:0] exp_rd;
    bit          known;
    @(negedge clk);
    chk("ready_pre", bus_a.ready, 1'b1);
    bus_a.req   = 1'b1;
    bus_a.we    = w;
    bus_a.addr  = ad;
    bus_a.wdata = wd;
    @(negedge clk);
    bus_a.req   = 1'b0;
    bus_a.we    = 1'($urandom);
    bus_a.addr  = 16'($urandom);
    bus_a.wdata = 16'($urandom);
    lat = 1;
    while (!bus_a.ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 16'(lat), 16'(WA + 1));
    in_r = (ad < 16'(DEPTH));
    chk("err", bus_a.err, !in_r);
    if (w) begin
      if (in_r) begin
        mm[ad[7:0]] = wd;
        mv[ad[7:0]] = 1'b1;
      end
      if (last_known) chk("rdata_on_write", bus_a.rdata, last_rd);
    end else begin
      exp_rd = in_r ? mm[ad[7:0]] : 16'h0000;
      known  = in_r ? mv[ad[7:0]] : 1'b1;
      if (known) chk("rdata", bus_a.rdata, exp_rd);
      last_rd    = exp_rd;
      last_known = known;
    end
    @(negedge clk);
    chk("ack_single", bus_a.ack, 1'b0);
    chk("err_clear", bus_a.err, 1'b0);
    chk("ready_post", bus_a.ready, 1'b1);
    if (last_known) chk("rdata_hold", bus_a.rdata, last_rd);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    last_rd    = 16'h0000;
    last_known = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = 16'h0; bus_a.wdata = 16'h0;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = 16'h0; bus_b.wdata = 16'h0;
    #1;
    chk("rst_ready", bus_a.ready, 1'b1);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_ack", bus_a.ack, 1'b0);
    chk("rst_err", bus_a.err, 1'b0);
    chk("rst_rdata", bus_a.rdata, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Basic write/read and out-of-range handling
    a_txn(1'b1, 16'h0009, 16'h5A5A);
    a_txn(1'b1, 16'h0007, 16'h1111);
    a_txn(1'b1, 16'h0005, 16'hBEEF);
    a_txn(1'b0, 16'h0005, 16'h0000);
    a_txn(1'b1, 16'h0105, 16'h1234);
    a_txn(1'b0, 16'h0005, 16'h0000);
    a_txn(1'b0, 16'h0100, 16'h0000);

    // Held req: captured address wins, next accept in cycle 4
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 16'h0005;
    @(negedge clk);
    chk("held_ready_c1", bus_a.ready, 1'b0);
    chk("held_busy_c1", bus_a.busy, 1'b1);
    bus_a.addr = 16'h0009;
    @(negedge clk);
    chk("held_ready_c2", bus_a.ready, 1'b0);
    chk("held_busy_c2", bus_a.busy, 1'b1);
    @(negedge clk);
    chk("held_ready_c3", bus_a.ready, 1'b0);
    chk("held_busy_c3", bus_a.busy, 1'b1);
    chk("held_ack_c3", bus_a.ack, 1'b1);
    chk("held_rdata_c3", bus_a.rdata, 16'hBEEF);
    @(negedge clk);
    chk("held_ready_c4", bus_a.ready, 1'b1);
    chk("held_ack_c4", bus_a.ack, 1'b0);
    @(negedge clk);
    bus_a.req = 1'b0;
    chk("held_busy_c5", bus_a.busy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("held_ack_c7", bus_a.ack, 1'b1);
    chk("held_rdata_c7", bus_a.rdata, 16'h5A5A);
    last_rd = 16'h5A5A;

    // rdata hold across a write
    a_txn(1'b0, 16'h0005, 16'h0000);
    a_txn(1'b1, 16'h0006, 16'h4321);
    chk("hold_after_write", bus_a.rdata, 16'hBEEF);

    // Reset mid-WAIT aborts the pending write
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 16'h0007; bus_a.wdata = 16'hAAAA;
    @(negedge clk);
    bus_a.req = 1'b0;
    rst_a = 1'b1;
    #1;
    chk("rstw_ack", bus_a.ack, 1'b0);
    chk("rstw_busy", bus_a.busy, 1'b0);
    chk("rstw_err", bus_a.err, 1'b0);
    chk("rstw_rdata", bus_a.rdata, 16'h0000);
    chk("rstw_ready", bus_a.ready, 1'b1);
    @(negedge clk);
    rst_a = 1'b0;
    last_rd = 16'h0000;
    last_known = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstw_no_ack", bus_a.ack, 1'b0);
    end
    a_txn(1'b0, 16'h0007, 16'h0000);

    // Reset during the ack cycle drops ack immediately
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 16'h0005;
    @(negedge clk);
    bus_a.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstr_ack_before", bus_a.ack, 1'b1);
    rst_a = 1'b1;
    #1;
    chk("rstr_ack_drop", bus_a.ack, 1'b0);
    chk("rstr_rdata", bus_a.rdata, 16'h0000);
    @(negedge clk);
    rst_a = 1'b0;
    last_rd = 16'h0000;
    last_known = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic        w;
      logic [15:0] ad;
      w  = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a_txn(w, ad, 16'($urandom));
    end

    // Zero wait states on instance B
    @(negedge clk);
    bus_b.req = 1'b1; bus_b.we = 1'b1; bus_b.addr = 16'h0005; bus_b.wdata = 16'hBEEF;
    @(negedge clk);
    bus_b.req = 1'b0;
    chk("b_wr_ack_c1", bus_b.ack, 1'b1);
    chk("b_wr_err_c1", bus_b.err, 1'b0);
    chk("b_wr_ready_c1", bus_b.ready, 1'b0);
    @(negedge clk);
    chk("b_wr_ack_c2", bus_b.ack, 1'b0);
    chk("b_wr_ready_c2", bus_b.ready, 1'b1);
    bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 16'h0005;
    @(negedge clk);
    bus_b.req = 1'b0;
    chk("b_rd_ack_c1", bus_b.ack, 1'b1);
    chk("b_rd_rdata_c1", bus_b.rdata, 16'hBEEF);
    @(negedge clk);
    chk("b_rd_ack_c2", bus_b.ack, 1'b0);
    chk("b_rd_ready_c2", bus_b.ready, 1'b1);
    chk("b_rd_hold_c2", bus_b.rdata, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
